// File: rtl/mcp23017_pkg.sv
// rtl/mcp23017_pkg.sv - MCP23017 register map, sequencer state encoding and request record
// Contents: register addresses, init-table length per chip, FSM state constants,
//           request record packed into the request FIFO, init/GPIO register lookups.
package mcp23017_pkg;

  localparam logic [7:0] REG_IODIRA = 8'h00;
  localparam logic [7:0] REG_IODIRB = 8'h01;
  localparam logic [7:0] REG_GPIOA  = 8'h12;
  localparam logic [7:0] REG_GPIOB  = 8'h13;

  localparam int INIT_STEPS_PER_CHIP = 4;

  localparam logic [2:0] S_INIT_ISSUE = 3'd0;
  localparam logic [2:0] S_INIT_WAIT  = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_WAIT       = 3'd4;

  typedef struct packed {
    logic [2:0] chip;
    logic       port;
    logic [7:0] data;
  } req_t;

  function automatic logic [7:0] init_reg(input logic [1:0] step);
    case (step)
      2'd0:    return REG_IODIRA;
      2'd1:    return REG_IODIRB;
      2'd2:    return REG_GPIOA;
      default: return REG_GPIOB;
    endcase
  endfunction

  function automatic logic [7:0] gpio_reg(input logic port);
    return port ? REG_GPIOB : REG_GPIOA;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers
// Ports: clk, rst_n (async active-low); push/wdata write side; pop/rdata read side
//        (rdata shows the head entry while not empty); full, empty flags.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mcp23017_sequencer.sv
// rtl/mcp23017_sequencer.sv - init + queued GPIO write sequencer for MCP23017 expanders
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_chip/req_port/req_data
//        request handshake; wr_en/hardware_address/register_address/data_out/wr_done
//        writer interface; init_done, busy, err_addr, err_timeout status;
//        shadow = per-chip {GPIOB, GPIOA} copy, chip c at [16c+15:16c].
module mcp23017_sequencer
  import mcp23017_pkg::*;
#(
  parameter int NUM_CHIPS      = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int SKIP_REDUNDANT = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_chip,
  input  logic                   req_port,
  input  logic [7:0]             req_data,
  output logic                   wr_en,
  output logic [2:0]             hardware_address,
  output logic [7:0]             register_address,
  output logic [7:0]             data_out,
  input  logic                   wr_done,
  output logic                   init_done,
  output logic                   busy,
  output logic                   err_addr,
  output logic                   err_timeout,
  output logic [16*NUM_CHIPS-1:0] shadow
);

  localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [4:0] INIT_LAST = 5'(INIT_STEPS_PER_CHIP * NUM_CHIPS - 1);
  localparam logic [3:0] CHIP_LIM  = 4'(NUM_CHIPS);

  logic [2:0]    state;
  logic [4:0]    init_idx;
  logic [TW-1:0] tmo_cnt;
  logic          timed_out;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [11:0]   fifo_rdata;
  req_t          head;
  logic          chip_ok;
  logic [7:0]    cur_byte;
  logic          redundant;

  assign req_ready = !fifo_full;
  assign chip_ok   = ({1'b0, req_chip} < CHIP_LIM);
  // Out-of-range chips are accepted (handshake completes) but never stored.
  assign fifo_push = req_valid && req_ready && chip_ok;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign head      = req_t'(fifo_rdata);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  sync_fifo #(
    .WIDTH(12),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({req_chip, req_port, req_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cur_byte = 8'h00;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      if (head.chip == 3'(c)) cur_byte = head.port ? shadow[16*c+8 +: 8] : shadow[16*c +: 8];
    end
  end

  assign redundant = (SKIP_REDUNDANT != 0) && (head.data == cur_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_INIT_ISSUE;
      init_idx         <= '0;
      tmo_cnt          <= '0;
      wr_en            <= 1'b0;
      hardware_address <= '0;
      register_address <= '0;
      data_out         <= '0;
      init_done        <= 1'b0;
      busy             <= 1'b0;
      err_addr         <= 1'b0;
      err_timeout      <= 1'b0;
      shadow           <= '0;
    end else begin
      wr_en <= 1'b0;
      // Registered, so it reads 0 in reset and trails the FSM by one cycle.
      busy  <= (state != S_IDLE) || !fifo_empty;
      if (req_valid && req_ready && !chip_ok) err_addr <= 1'b1;

      case (state)
        S_INIT_ISSUE: begin
          hardware_address <= init_idx[4:2];
          register_address <= init_reg(init_idx[1:0]);
          data_out         <= 8'h00;
          wr_en            <= 1'b1;
          tmo_cnt          <= '0;
          state            <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (wr_done || timed_out) begin
            if (!wr_done) err_timeout <= 1'b1;
            if (init_idx == INIT_LAST) begin
              init_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              init_idx <= init_idx + 5'd1;
              state    <= S_INIT_ISSUE;
            end
          end
        end
        S_IDLE: begin
          if (!fifo_empty && !redundant) begin
            hardware_address <= head.chip;
            register_address <= gpio_reg(head.port);
            data_out         <= head.data;
            wr_en            <= 1'b1;
            // Shadow is visible in the same cycle the strobe is presented.
            for (int c = 0; c < NUM_CHIPS; c++) begin
              if (head.chip == 3'(c)) begin
                if (head.port) shadow[16*c+8 +: 8] <= head.data;
                else           shadow[16*c +: 8]   <= head.data;
              end
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (wr_done || timed_out) begin
            if (!wr_done) err_timeout <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp23017_sequencer.sv
// tb/tb_mcp23017_sequencer.sv - self-checking bench for mcp23017_sequencer
module tb_mcp23017_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_chip;
  logic        req_port;
  logic [7:0]  req_data;
  logic        wr_en;
  logic [2:0]  hardware_address;
  logic [7:0]  register_address;
  logic [7:0]  data_out;
  logic        wr_done;
  logic        init_done;
  logic        busy;
  logic        err_addr;
  logic        err_timeout;
  logic [31:0] shadow;

  always #5 clk = ~clk;

  mcp23017_sequencer #(
    .NUM_CHIPS(2), .FIFO_DEPTH(4), .SKIP_REDUNDANT(1), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chip(req_chip), .req_port(req_port), .req_data(req_data),
    .wr_en(wr_en), .hardware_address(hardware_address),
    .register_address(register_address), .data_out(data_out), .wr_done(wr_done),
    .init_done(init_done), .busy(busy), .err_addr(err_addr),
    .err_timeout(err_timeout), .shadow(shadow)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] rg;
    logic [7:0] data;
  } exp_wr_t;

  typedef struct {
    logic [2:0] chip;
    logic       port;
    logic [7:0] data;
    logic       exp_wr;
  } vec_t;

  exp_wr_t    sb[$];
  logic [7:0] m_sh [2][2];
  int         checks   = 0;
  int         failures = 0;
  int         wr_count = 0;
  bit         hold_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    return {m_sh[1][1], m_sh[1][0], m_sh[0][1], m_sh[0][0]};
  endfunction

  task automatic expect_req(input logic [2:0] c, input logic p, input logic [7:0] d);
    exp_wr_t e;
    e.addr = c;
    e.rg   = p ? 8'h13 : 8'h12;
    e.data = d;
    sb.push_back(e);
    m_sh[c[0]][p] = d;
  endtask

  task automatic expect_init();
    exp_wr_t e;
    logic [7:0] regs [4];
    regs[0] = 8'h00; regs[1] = 8'h01; regs[2] = 8'h12; regs[3] = 8'h13;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        e.addr = 3'(c);
        e.rg   = regs[r];
        e.data = 8'h00;
        sb.push_back(e);
      end
    end
  endtask

  // Writer model: acknowledges three cycles after each strobe unless held off.
  initial begin
    int pend = 0;
    wr_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      wr_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) wr_done = 1'b1;
      end
      if (wr_en && !hold_done) pend = 3;
    end
  end

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr: actual=%0h/%0h/%0h required=none",
                 hardware_address, register_address, data_out);
      end else begin
        exp_wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(hardware_address), 32'(e.addr));
        chk("wr_reg",  32'(register_address), 32'(e.rg));
        chk("wr_data", 32'(data_out),         32'(e.data));
      end
    end
  end

  task automatic push(input logic [2:0] c, input logic p, input logic [7:0] d);
    bit ok = 1'b0;
    req_chip = c; req_port = p; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_init(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (init_done) done = 1'b1;
    end
    chk({tag, "_init_done"}, 32'(done), 32'd1);
    chk({tag, "_init_writes"}, 32'(wr_count), 32'd8);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},     32'(wr_en),            32'd0);
    chk({tag, "_ready"},     32'(req_ready),        32'd1);
    chk({tag, "_init_done"}, 32'(init_done),        32'd0);
    chk({tag, "_busy"},      32'(busy),             32'd0);
    chk({tag, "_err_addr"},  32'(err_addr),         32'd0);
    chk({tag, "_err_tmo"},   32'(err_timeout),      32'd0);
    chk({tag, "_shadow"},    shadow,                32'd0);
    chk({tag, "_outs"},      {13'd0, hardware_address, register_address, data_out}, 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    bit seen;
    vecs[0] = '{3'd1, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{3'd1, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{3'd0, 1'b0, 8'h11, 1'b0};
    vecs[3] = '{3'd0, 1'b0, 8'h5A, 1'b1};
    vecs[4] = '{3'd1, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{3'd0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{3'd0, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{3'd1, 1'b0, 8'hFF, 1'b1};
    for (int c = 0; c < 2; c++) for (int p = 0; p < 2; p++) m_sh[c][p] = 8'h00;

    rst_n = 1'b0; req_valid = 1'b0; req_chip = '0; req_port = 1'b0; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Init plus FIFO fill during init.
    expect_init();
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_req(3'd0, 1'b0, 8'h11);
    push(3'd0, 1'b0, 8'h11);
    expect_req(3'd1, 1'b1, 8'h22);
    push(3'd1, 1'b1, 8'h22);
    expect_req(3'd0, 1'b1, 8'h33);
    push(3'd0, 1'b1, 8'h33);
    expect_req(3'd1, 1'b0, 8'h44);
    push(3'd1, 1'b0, 8'h44);
    @(negedge clk);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("init_pending", 32'(init_done), 32'd0);
    @(posedge clk); #1;
    req_chip = 3'd0; req_port = 1'b0; req_data = 8'h55; req_valid = 1'b1;
    @(negedge clk);
    chk("fifth_refused", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_init("boot");
    wait_idle("fill");
    chk("fill_shadow", shadow, m_word());
    chk("no_err_addr", 32'(err_addr), 32'd0);
    chk("no_err_tmo", 32'(err_timeout), 32'd0);

    // Table-driven requests, including redundant ones.
    foreach (vecs[i]) begin
      if (vecs[i].exp_wr) expect_req(vecs[i].chip, vecs[i].port, vecs[i].data);
      push(vecs[i].chip, vecs[i].port, vecs[i].data);
      if (!vecs[i].exp_wr) begin
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d_busy_drop", i), 32'(busy), 32'd0);
        @(posedge clk); #1;
      end
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_shadow", i), shadow, m_word());
    end
    chk("shadow_chip1_b", 32'(shadow[31:24]), 32'(m_sh[1][1]));

    // Bad chip address then a timed-out write.
    push(3'd5, 1'b0, 8'h12);
    wait_idle("badaddr");
    chk("err_addr_set", 32'(err_addr), 32'd1);
    chk("badaddr_shadow", shadow, m_word());
    hold_done = 1'b1;
    expect_req(3'd0, 1'b0, 8'h77);
    push(3'd0, 1'b0, 8'h77);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (err_timeout) seen = 1'b1;
    end
    chk("err_timeout_set", 32'(seen), 32'd1);
    @(posedge clk); #1;
    hold_done = 1'b0;
    expect_req(3'd1, 1'b1, 8'h3C);
    push(3'd1, 1'b1, 8'h3C);
    wait_idle("after_tmo");
    chk("after_tmo_shadow", shadow, m_word());

    // Reset while a write is outstanding.
    hold_done = 1'b1;
    expect_req(3'd1, 1'b0, 8'h81);
    push(3'd1, 1'b0, 8'h81);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (sb.size() == 0) seen = 1'b1;
    end
    chk("midreset_issued", 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    sb.delete();
    for (int c = 0; c < 2; c++) for (int p = 0; p < 2; p++) m_sh[c][p] = 8'h00;
    hold_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_init();
    wr_count = 0;
    rst_n = 1'b1;
    wait_init("rerun");
    wait_idle("rerun");
    chk("rerun_shadow", shadow, m_word());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
